// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: holds the fetch PC, issues req/gnt word fetches, and
// buffers returned words with their PCs in an in-order queue feeding IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        be_i,
    input  logic [31:0] baddr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        adel_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH, FAULT} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   fault_addr;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   tag    [DEPTH];
    logic [PW-1:0] head, tail, tag_wr, tag_rd;
    logic [CW-1:0] count, outst, drop, owed;
    logic          marker_done;
    logic          xfer, push, pop, qpop, q_valid, marker_valid;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request credit covers both queued and in-flight words, dropped ones included.
    assign imem_req_o  = !rst && (state == FETCH) &&
                         (({1'b0, outst} + {1'b0, count}) < DEPTH_W);
    assign imem_addr_o = fetch_pc;
    assign xfer        = imem_req_o && imem_gnt_i;
    assign owed        = outst + CW'(xfer) - CW'(imem_rvalid_i);

    assign q_valid      = (state == FETCH) && (count != '0);
    assign marker_valid = (state == FAULT) && (drop == '0) && (count == '0) && !marker_done;
    assign valid_o      = q_valid || marker_valid;
    assign pc_o         = q_valid ? q_pc[head] : (marker_valid ? fault_addr : '0);
    assign inst_o       = q_valid ? q_inst[head] : '0;
    assign adel_o       = marker_valid;

    assign pop  = valid_o && !stall_i && !be_i;
    assign qpop = pop && q_valid;
    assign push = imem_rvalid_i && (drop == '0) && !be_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            fault_addr  <= '0;
            head        <= '0;
            tail        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            count       <= '0;
            outst       <= '0;
            drop        <= '0;
            marker_done <= 1'b0;
        end else begin
            outst <= owed;
            if (be_i) begin
                head     <= '0;
                tail     <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
                count    <= '0;
                drop     <= owed;
                fetch_pc <= baddr_i;
                if (baddr_i[1:0] != 2'b00) begin
                    state       <= FAULT;
                    fault_addr  <= baddr_i;
                    marker_done <= 1'b0;
                end else begin
                    state <= FETCH;
                end
            end else begin
                if (xfer) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= inc(tag_wr);
                end
                if (imem_rvalid_i) begin
                    if (drop != '0) drop <= drop - 1'b1;
                    else            tag_rd <= inc(tag_rd);
                end
                if (push) tail <= inc(tail);
                if (qpop) head <= inc(head);
                count <= count + CW'(push) - CW'(qpop);
                if (marker_valid && pop) marker_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && !be_i) tag[tag_wr] <= fetch_pc;
        if (push) begin
            q_pc[tail]   <= tag[tag_rd];
            q_inst[tail] <= imem_rdata_i;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order instruction memory model
// returning word (addr | 32'hC0DE_0000) one cycle after grant.
module tb_if_fetch_unit;
    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        be_i;
    logic [31:0] baddr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        adel_o;

    int          checks = 0;
    int          errors = 0;
    logic        mem_hold;
    logic [31:0] mq[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .be_i(be_i), .baddr_i(baddr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .adel_o(adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: the memory model records a granted address and answers the
    // oldest pending one in the following cycle unless held.
    task automatic tick();
        logic        x;
        logic [31:0] a;
        x = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        @(posedge clk);
        #1;
        if (x) mq.push_back(a);
        if (!mem_hold && mq.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mq.pop_front() | 32'hC0DE_0000;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        imem_gnt_i    = 1'b1;
        mem_hold      = 1'b0;
        stall_i       = 1'b0;
        be_i          = 1'b0;
        baddr_i       = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic adel);
        stall_i = 1'b0;
        be_i    = 1'b0;
        wait_valid(tag);
        check({tag, "_pc"}, pc_o, pc);
        check({tag, "_inst"}, inst_o, inst);
        check({tag, "_adel"}, 32'(adel_o), 32'(adel));
        tick();
    endtask

    initial begin
        // 1: reset values, first-word latency, in-order delivery
        rst = 1'b1;
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0000_0000);
        check("rst_pc", pc_o, 32'h0);
        check("rst_adel", 32'(adel_o), 32'd0);
        do_reset();
        check("c1_req", 32'(imem_req_o), 32'd1);
        check("c1_addr", imem_addr_o, 32'h0000_0000);
        check("c1_valid", 32'(valid_o), 32'd0);
        tick();
        check("c2_valid", 32'(valid_o), 32'd0);
        check("c2_addr", imem_addr_o, 32'h0000_0004);
        tick();
        check("c3_valid", 32'(valid_o), 32'd1);
        expect_pop("t1_a", 32'h0, 32'hC0DE_0000, 1'b0);
        expect_pop("t1_b", 32'h4, 32'hC0DE_0004, 1'b0);
        expect_pop("t1_c", 32'h8, 32'hC0DE_0008, 1'b0);

        // 2: stall fills the queue, requests stop, nothing lost
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t2_req_off", 32'(imem_req_o), 32'd0);
        check("t2_head_pc", pc_o, 32'h0);
        check("t2_head_inst", inst_o, 32'hC0DE_0000);
        expect_pop("t2_a", 32'h0, 32'hC0DE_0000, 1'b0);
        expect_pop("t2_b", 32'h4, 32'hC0DE_0004, 1'b0);
        expect_pop("t2_c", 32'h8, 32'hC0DE_0008, 1'b0);
        expect_pop("t2_d", 32'hC, 32'hC0DE_000C, 1'b0);

        // 3: redirect with two words in flight; both must be dropped
        do_reset();
        mem_hold = 1'b1;
        tick();
        tick();
        check("t3_req_full", 32'(imem_req_o), 32'd0);
        be_i    = 1'b1;
        baddr_i = 32'h0000_0100;
        mem_hold = 1'b0;
        tick();
        be_i = 1'b0;
        check("t3_addr", imem_addr_o, 32'h0000_0100);
        check("t3_req_owed", 32'(imem_req_o), 32'd0);
        check("t3_valid", 32'(valid_o), 32'd0);
        expect_pop("t3_a", 32'h100, 32'hC0DE_0100, 1'b0);
        expect_pop("t3_b", 32'h104, 32'hC0DE_0104, 1'b0);

        // 4: redirect coinciding with rvalid and a granted request
        do_reset();
        tick();
        check("t4_rvalid", 32'(imem_rvalid_i && imem_req_o), 32'd1);
        be_i    = 1'b1;
        baddr_i = 32'h0000_0200;
        tick();
        be_i = 1'b0;
        check("t4_addr", imem_addr_o, 32'h0000_0200);
        check("t4_valid", 32'(valid_o), 32'd0);
        expect_pop("t4_a", 32'h200, 32'hC0DE_0200, 1'b0);
        expect_pop("t4_b", 32'h204, 32'hC0DE_0204, 1'b0);

        // 5: misaligned redirect yields one marker, then idles until realigned
        do_reset();
        tick();
        be_i    = 1'b1;
        baddr_i = 32'h0000_0102;
        tick();
        be_i = 1'b0;
        check("t5_req_off", 32'(imem_req_o), 32'd0);
        check("t5_valid_drop", 32'(valid_o), 32'd0);
        expect_pop("t5_mark", 32'h102, 32'h0, 1'b1);
        tick();
        tick();
        tick();
        check("t5_idle_valid", 32'(valid_o), 32'd0);
        check("t5_idle_req", 32'(imem_req_o), 32'd0);
        be_i    = 1'b1;
        baddr_i = 32'h0000_0200;
        tick();
        be_i = 1'b0;
        check("t5_resume_req", 32'(imem_req_o), 32'd1);
        check("t5_resume_addr", imem_addr_o, 32'h0000_0200);
        expect_pop("t5_a", 32'h200, 32'hC0DE_0200, 1'b0);

        // 6: PC wrap, then asynchronous reset mid-burst
        do_reset();
        be_i    = 1'b1;
        baddr_i = 32'hFFFF_FFFC;
        tick();
        be_i = 1'b0;
        check("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("t6_addr_wrap", imem_addr_o, 32'h0000_0000);
        expect_pop("t6_a", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        wait_valid("t6_b");
        check("t6_b_pc", pc_o, 32'h0000_0000);
        check("t6_b_inst", inst_o, 32'hC0DE_0000);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_valid", 32'(valid_o), 32'd0);
        check("t6_arst_req", 32'(imem_req_o), 32'd0);
        check("t6_arst_pc", pc_o, 32'h0);
        check("t6_arst_inst", inst_o, 32'h0);
        check("t6_arst_addr", imem_addr_o, 32'h0000_0000);
        do_reset();
        expect_pop("t6_post", 32'h0, 32'hC0DE_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
